// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_pkg
// Brief    : Shared state encoding and sizing helper for bin2bcd_seq.
// Revision : 1.0  initial release
// ============================================================================
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must hold the value BIN_W itself.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Shift-add-3 correction for one BCD digit (+3 when digit > 4).
// Revision : 1.0  initial release
// ============================================================================
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Digits only reach 9 between shifts, so the sum never exceeds 12.
  assign o_digit = (i_digit > 4'd4) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential binary-to-BCD converter, one bit per clock, with
//            valid/ready handshake, optional signed input and overflow flag.
// Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_neg,
  output logic                out_ovf
);

  localparam int               BCD_W      = 4 * DIGITS;
  localparam int               CNT_W      = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_mag;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_neg;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic [BCD_W-1:0]   w_adj;
  logic               w_carry;
  logic [BCD_W-1:0]   w_bcd_sh;
  logic [BIN_W-1:0]   w_mag_sh;
  logic               w_neg_load;
  logic [BIN_W-1:0]   w_mag_load;
  logic               w_accept;
  logic               w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The bit falling out of the top digit is a decimal carry beyond DIGITS.
  assign {w_carry, w_bcd_sh, w_mag_sh} = {w_adj, r_mag, 1'b0};

  // BIN_W-bit negation maps the most negative value onto its true magnitude.
  assign w_neg_load = SIGNED && bin[BIN_W-1];
  assign w_mag_load = w_neg_load ? (-bin) : bin;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == C_CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = (r_state == ST_IDLE) && !rst;
    out_valid   = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE:  if (w_accept)  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag   <= '0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      out_bcd <= '0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mag <= w_mag_load;
        r_bcd <= '0;
        r_neg <= w_neg_load;
        r_ovf <= 1'b0;
        r_cnt <= C_CNT_LOAD;
      end else if (r_state == ST_SHIFT) begin
        r_mag <= w_mag_sh;
        r_bcd <= w_bcd_sh;
        r_ovf <= r_ovf | w_carry;
        r_cnt <= r_cnt - C_CNT_ONE;
      end
      // Result registers update only on the final shift so they hold in IDLE.
      if (w_last) begin
        out_bcd <= w_bcd_sh;
        out_neg <= r_neg;
        out_ovf <= r_ovf | w_carry;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Scoreboard bench for bin2bcd_seq in three configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;

  typedef struct {
    logic [11:0] bcd;
    logic        neg;
    logic        ovf;
    int          acc;
    int          bw;
  } exp_t;

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic        neg;
    logic        ovf;
    logic [11:0] bcd;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_valid  = 3'b000;
  logic [2:0] out_ready = 3'b111;
  logic [8:0] bin0 = '0;
  logic [7:0] bin1 = '0;
  logic [7:0] bin2 = '0;

  logic        rdy0, vld0, neg0, ovf0;
  logic        rdy1, vld1, neg1, ovf1;
  logic        rdy2, vld2, neg2, ovf2;
  logic [11:0] bcd0, bcd2;
  logic [7:0]  bcd1;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   sel = 0;
  bit   rnd = 1'b0;
  bit   seen = 1'b0;
  exp_t sb[$];
  exp_t me;
  obs_t mo;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.BIN_W(9), .DIGITS(3), .SIGNED(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy0), .bin(bin0),
    .out_valid(vld0), .out_ready(out_ready[0]), .out_bcd(bcd0), .out_neg(neg0), .out_ovf(ovf0));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy1), .bin(bin1),
    .out_valid(vld1), .out_ready(out_ready[1]), .out_bcd(bcd1), .out_neg(neg1), .out_ovf(ovf1));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy2), .bin(bin2),
    .out_valid(vld2), .out_ready(out_ready[2]), .out_bcd(bcd2), .out_neg(neg2), .out_ovf(ovf2));

  function automatic obs_t obs(input int s);
    obs_t o;
    case (s)
      0:       o = {rdy0, vld0, neg0, ovf0, bcd0};
      1:       o = {rdy1, vld1, neg1, ovf1, 4'h0, bcd1};
      default: o = {rdy2, vld2, neg2, ovf2, bcd2};
    endcase
    return o;
  endfunction

  // Reference: plain decimal arithmetic on the operand's magnitude.
  function automatic exp_t model(input int s, input int v);
    exp_t e;
    int bw, dig, mag, lim, m;
    bit sgn;
    bw  = (s == 0) ? 9 : 8;
    dig = (s == 1) ? 2 : 3;
    sgn = (s == 2);
    mag = v;
    e.neg = 1'b0;
    if (sgn && (((v >> (bw - 1)) & 1) == 1)) begin
      mag   = (1 << bw) - v;
      e.neg = 1'b1;
    end
    lim   = 10 ** dig;
    e.ovf = (mag >= lim);
    m     = mag % lim;
    e.bcd = '0;
    for (int d = 0; d < dig; d++) begin
      e.bcd[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.bw  = bw;
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd) out_ready[sel] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_bin(input int s, input int v);
    case (s)
      0:       bin0 = v[8:0];
      1:       bin1 = v[7:0];
      default: bin2 = v[7:0];
    endcase
  endtask

  task automatic send(input int s, input int v, input bit push);
    int   t;
    obs_t o;
    exp_t e;
    t = 0;
    drive_bin(s, v);
    in_valid[s] = 1'b1;
    o = obs(s);
    while (!o.rdy && t < 200) begin
      tick();
      t++;
      o = obs(s);
    end
    if (!o.rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=0 required 1 within 200 cycles");
      in_valid[s] = 1'b0;
    end else begin
      if (push) begin
        e     = model(s, v);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      tick();
      in_valid[s] = 1'b0;
      o = obs(s);
      chk("in_ready_busy", int'(o.rdy), 0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    chk("drain_pending", sb.size(), 0);
    rnd = 1'b0;
    out_ready = 3'b111;
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always begin
    @(negedge clk);
    #1;
    mo = obs(sel);
    if (mo.vld) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: out_valid=1 required 0 (bcd %0h)", mo.bcd);
      end else begin
        me = sb[0];
        if (!seen) chk("latency", cyc - me.acc, me.bw);
        seen = 1'b1;
        chk("out_bcd", int'(mo.bcd), int'(me.bcd));
        chk("out_neg", int'(mo.neg), int'(me.neg));
        chk("out_ovf", int'(mo.ovf), int'(me.ovf));
        if (out_ready[sel]) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    obs_t o;
    int   t;
    repeat (3) tick();
    o = obs(0);
    chk("rst_out_valid", int'(o.vld), 0);
    chk("rst_out_bcd", int'(o.bcd), 0);
    chk("rst_in_ready", int'(o.rdy), 0);
    rst = 1'b0;
    #1;
    o = obs(0);
    chk("idle_in_ready", int'(o.rdy), 1);

    // Basic conversion, then back-to-back full-scale and zero.
    send(0, 255, 1'b1);
    drain();
    send(0, 511, 1'b1);
    send(0, 0, 1'b1);
    drain();

    // Consumer stall: result must hold and new requests be ignored.
    out_ready[0] = 1'b0;
    send(0, 300, 1'b1);
    t = 0;
    o = obs(0);
    while (!o.vld && t < 30) begin
      tick();
      t++;
      o = obs(0);
    end
    chk("stall_out_valid", int'(o.vld), 1);
    for (int i = 0; i < 6; i++) begin
      in_valid[0] = 1'b1;
      bin0 = 9'd7;
      tick();
      o = obs(0);
      chk("stall_in_ready", int'(o.rdy), 0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    drain();
    tick();
    o = obs(0);
    chk("idle_hold_valid", int'(o.vld), 0);
    chk("idle_hold_bcd", int'(o.bcd), 12'h300);

    // Reset on the 4th shift cycle aborts the conversion.
    send(0, 123, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    o = obs(0);
    chk("abort_out_valid", int'(o.vld), 0);
    chk("abort_out_bcd", int'(o.bcd), 0);
    chk("abort_out_neg", int'(o.neg), 0);
    chk("abort_out_ovf", int'(o.ovf), 0);
    chk("abort_in_ready", int'(o.rdy), 0);
    rst = 1'b0;
    #1;
    o = obs(0);
    chk("post_rst_in_ready", int'(o.rdy), 1);
    repeat (12) tick();

    // Full sweep of the default configuration with random back-pressure.
    rnd = 1'b1;
    for (int v = 0; v < 512; v++) send(0, v, 1'b1);
    drain();

    // Two-digit configuration: overflow and exact fit.
    sel = 1;
    send(1, 200, 1'b1);
    send(1, 99, 1'b1);
    drain();
    rnd = 1'b1;
    for (int i = 0; i < 20; i++) send(1, int'($urandom_range(0, 255)), 1'b1);
    drain();

    // Signed configuration: most negative value and -1.
    sel = 2;
    send(2, 8'h80, 1'b1);
    send(2, 8'hFF, 1'b1);
    drain();
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) send(2, int'($urandom_range(0, 255)), 1'b1);
    drain();

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
